// File: rtl/inst_fetcher_if.sv
// Purpose: bundles the fetch-stage signals that face the memory controller,
//   the issue queue and the ROB.
// Handshake semantics (all single-cycle pulses, no back-pressure wires):
//   out_mem_ce is a one-cycle read request for out_mem_addr.
//   in_mem_ce is a one-cycle pulse marking in_mem_data valid.
//   out_inst_valid is a one-cycle pulse marking out_inst/out_pc valid.
//   in_queue_full=1 means the consumer cannot take an instruction this cycle.
//   in_rob_misbranch=1 means flush and redirect to in_rob_newpc.
// Modports: master = the fetcher, slave = its surroundings.
interface inst_fetcher_if;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce;
  logic [31:0] in_mem_data;
  logic        in_queue_full;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        in_rob_misbranch;
  logic [31:0] in_rob_newpc;

  modport master (
    output out_mem_ce, out_mem_addr, out_inst_valid, out_inst, out_pc,
    input  in_mem_ce, in_mem_data, in_queue_full, in_rob_misbranch, in_rob_newpc
  );

  modport slave (
    input  out_mem_ce, out_mem_addr, out_inst_valid, out_inst, out_pc,
    output in_mem_ce, in_mem_data, in_queue_full, in_rob_misbranch, in_rob_newpc
  );
endinterface

// File: rtl/inst_fetcher.sv
// Purpose: instruction-fetch stage with a direct-mapped, one-word-per-line
//   instruction cache. Delivers {inst, pc} one per cycle on hits, issues a
//   word read to the memory controller on a miss and fills the line.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   rdy          global enable; 0 freezes every register
//   bus          inst_fetcher_if.master (memory, issue queue, ROB signals)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = WAIT)
module inst_fetcher #(
  parameter int          ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  inst_fetcher_if.master  bus,
  output logic            dbg_state_o
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_ce_q, mem_ce_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic                    fill_en;

  assign idx = pc_q[ICACHE_IDX_W+1:2];
  assign tag = pc_q[31:ICACHE_IDX_W+2];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_ce_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    out_pc_d     = out_pc_q;
    fill_en      = 1'b0;
    if (bus.in_rob_misbranch) begin
      // Redirect wins; a response arriving in this cycle is dropped unfilled.
      pc_d    = bus.in_rob_newpc;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.in_queue_full) begin
            if (hit) begin
              inst_valid_d = 1'b1;
              inst_d       = data_q[idx];
              out_pc_d     = pc_q;
              pc_d         = pc_q + 32'd4;
            end else begin
              mem_ce_d   = 1'b1;
              mem_addr_d = {pc_q[31:2], 2'b00};
              state_d    = WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.in_mem_ce) begin
            fill_en = 1'b1;
            state_d = IDLE;
            // With the queue full we only fill; the next IDLE cycle hits.
            if (!bus.in_queue_full) begin
              inst_valid_d = 1'b1;
              inst_d       = bus.in_mem_data;
              out_pc_d     = pc_q;
              pc_d         = pc_q + 32'd4;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      mem_ce_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      out_pc_q     <= 32'h0;
      valid_q      <= '0;
    end else if (rdy) begin
      assert (!(state_q == IDLE && bus.in_mem_ce));
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_ce_q     <= mem_ce_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      out_pc_q     <= out_pc_d;
      if (fill_en) valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.in_mem_data;
    end
  end

  assign bus.out_mem_ce     = mem_ce_q;
  assign bus.out_mem_addr   = mem_addr_q;
  assign bus.out_inst_valid = inst_valid_q;
  assign bus.out_inst       = inst_q;
  assign bus.out_pc         = out_pc_q;
  assign dbg_state_o        = (state_q == WAIT);

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;
  logic clk;
  logic rst;
  logic rdy;
  logic dbg_state;
  int   checks;
  int   failures;

  inst_fetcher_if bus();

  inst_fetcher #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        mce;
    logic [31:0] mdata;
    logic        qf;
    logic        mb;
    logic [31:0] newpc;
    logic        emce;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einst;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input int step, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s actual=%h required=%h", step, name, act, exp);
    end
  endtask

  task automatic vec(input logic r, input logic mc, input logic [31:0] md, input logic qf,
                     input logic mb, input logic [31:0] np, input logic emc,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ep);
    vec_t v;
    v.rdy = r; v.mce = mc; v.mdata = md; v.qf = qf; v.mb = mb; v.newpc = np;
    v.emce = emc; v.eaddr = ea; v.evalid = ev; v.einst = ei; v.epc = ep;
    vecs.push_back(v);
  endtask

  // driver: apply one cycle of inputs, compare registered outputs after the edge
  task automatic run_vec(input vec_t v, input int step);
    rdy                  = v.rdy;
    bus.in_mem_ce        = v.mce;
    bus.in_mem_data      = v.mdata;
    bus.in_queue_full    = v.qf;
    bus.in_rob_misbranch = v.mb;
    bus.in_rob_newpc     = v.newpc;
    @(posedge clk);
    #1;
    check(step, "mem_ce", {31'b0, bus.out_mem_ce}, {31'b0, v.emce});
    if (v.emce) check(step, "mem_addr", bus.out_mem_addr, v.eaddr);
    check(step, "inst_valid", {31'b0, bus.out_inst_valid}, {31'b0, v.evalid});
    if (v.evalid) begin
      check(step, "inst", bus.out_inst, v.einst);
      check(step, "pc", bus.out_pc, v.epc);
    end
  endtask

  task automatic run_all(input int base);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], base + i);
  endtask

  task automatic check_zero_outputs(input int step);
    check(step, "rst_mem_ce", {31'b0, bus.out_mem_ce}, 32'h0);
    check(step, "rst_mem_addr", bus.out_mem_addr, 32'h0);
    check(step, "rst_inst_valid", {31'b0, bus.out_inst_valid}, 32'h0);
    check(step, "rst_inst", bus.out_inst, 32'h0);
    check(step, "rst_pc", bus.out_pc, 32'h0);
    check(step, "rst_state", {31'b0, dbg_state}, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rdy = 1'b1;
    bus.in_mem_ce = 1'b0;
    bus.in_mem_data = 32'h0;
    bus.in_queue_full = 1'b0;
    bus.in_rob_misbranch = 1'b0;
    bus.in_rob_newpc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs(0);
    rst = 1'b0;

    //   rdy mce mdata          qf mb newpc      emce eaddr       ev inst           pc
    // 1: cold misses on nops at 0..0xC
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000013,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h4,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000013,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h4);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h8,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000013,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h8);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'hC,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000013,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'hC);
    // 2: redirect to 0, four back-to-back hits with no request
    vec(1, 0, 32'h0,          0, 1, 32'h0,     0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h4);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h8);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'hC);
    // 3: response at 0x10 while queue full -> fill only, later hit
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h10,    0, 32'h0,          32'h0);
    vec(1, 1, 32'hAAAA0010,   1, 0, 32'h0,     0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          1, 0, 32'h0,     0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'hAAAA0010,   32'h10);
    // rdy=0 holds outputs, including a pending request pulse
    vec(0, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'hAAAA0010,   32'h10);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h14,    0, 32'h0,          32'h0);
    vec(0, 0, 32'h0,          0, 0, 32'h0,     1, 32'h14,    0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 1, 32'hBBBB0014,   0, 0, 32'h0,     0, 32'h0,     1, 32'hBBBB0014,   32'h14);
    // 4: misbranch to 0x100 in WAIT for 0x20, colliding with the response
    vec(1, 0, 32'h0,          0, 1, 32'h20,    0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h20,    0, 32'h0,          32'h0);
    vec(1, 1, 32'hDEAD0020,   0, 1, 32'h100,   0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h100,   0, 32'h0,          32'h0);
    vec(1, 1, 32'hCCCC0100,   0, 0, 32'h0,     0, 32'h0,     1, 32'hCCCC0100,   32'h100);
    // 0x20 was not filled: it must miss
    vec(1, 0, 32'h0,          0, 1, 32'h20,    0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h20,    0, 32'h0,          32'h0);
    vec(1, 1, 32'h11110020,   0, 0, 32'h0,     0, 32'h0,     1, 32'h11110020,   32'h20);
    // 5: 0x100 evicted line 0, so 0x0 misses; 0x4 still hits; 0x100 misses again
    vec(1, 0, 32'h0,          0, 1, 32'h0,     0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000013,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     0, 32'h0,     1, 32'h00000013,   32'h4);
    vec(1, 0, 32'h0,          0, 1, 32'h100,   0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h100,   0, 32'h0,          32'h0);
    vec(1, 1, 32'hCCCC0100,   0, 0, 32'h0,     0, 32'h0,     1, 32'hCCCC0100,   32'h100);
    // 6 setup: enter WAIT for 0x200
    vec(1, 0, 32'h0,          0, 1, 32'h200,   0, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h200,   0, 32'h0,          32'h0);
    run_all(1);

    // 6: asynchronous reset mid-WAIT clears outputs without a clock edge
    check(100, "wait_state", {31'b0, dbg_state}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs(101);
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs.delete();
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h0,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000077,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000077,   32'h0);
    vec(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h4,     0, 32'h0,          32'h0);
    vec(1, 1, 32'h00000088,   0, 0, 32'h0,     0, 32'h0,     1, 32'h00000088,   32'h4);
    run_all(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
